// File: rtl/pipe_mac.sv
// ---------------------------------------------------------------------------
// pipe_mac : pipelined multiply-accumulate with valid/ready handshaking.
//
// An operand beat (inp_a, inp_b plus its signed_mode/acc_en/acc_clr flags)
// is multiplied to a full 2*WIDTH product, extended to ACC_W and carried
// through STAGES-1 intermediate registers. The output register then either
// loads the plain product, clears-and-loads the accumulator, or adds into
// it. A stalled output (out_valid && !out_ready) freezes the whole pipe.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand beat offered
//   in_ready     beat accepted when in_valid && in_ready at a rising edge
//   inp_a/inp_b  operands, WIDTH bits
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   acc_en       beat adds its product into the accumulator
//   acc_clr      beat clears the accumulator first (wins over acc_en)
//   out_valid    prod holds a result
//   out_ready    result consumed when out_valid && out_ready at an edge
//   prod         result, ACC_W bits
//   acc_ovf      sticky accumulator overflow flag
// ---------------------------------------------------------------------------
module pipe_mac #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter int ACC_W  = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inp_a,
   input  logic [WIDTH-1:0] inp_b,
   input  logic             signed_mode,
   input  logic             acc_en,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] prod,
   output logic             acc_ovf
);

   // Full-width product, sign- or zero-extended to the accumulator width.
   // Operands are widened to 2*WIDTH before multiplying so the product
   // modulo 2^(2*WIDTH) is the exact product in either mode.
   function automatic logic signed [ACC_W-1:0] ext_mul(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sm
   );
      logic signed [2*WIDTH-1:0] ps;
      logic        [2*WIDTH-1:0] pu;
      ps = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      pu = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      if (sm)
         return ACC_W'(ps);
      else
         return ACC_W'(pu);
   endfunction

   // Wrapping add; MSB of the result is the overflow flag for the mode:
   // carry-out when unsigned, like-signed operands giving a differently
   // signed sum when signed.
   function automatic logic [ACC_W:0] acc_add(
      input logic [ACC_W-1:0] acc_v,
      input logic [ACC_W-1:0] ext_v,
      input logic             sm
   );
      logic [ACC_W:0] s;
      logic           ovf;
      s = {1'b0, acc_v} + {1'b0, ext_v};
      if (sm)
         ovf = (acc_v[ACC_W-1] == ext_v[ACC_W-1]) && (s[ACC_W-1] != acc_v[ACC_W-1]);
      else
         ovf = s[ACC_W];
      return {ovf, s[ACC_W-1:0]};
   endfunction

   logic                    stall;
   logic signed [ACC_W-1:0] ext_in;

   // Signals entering the output register.
   logic                    vld_o;
   logic        [ACC_W-1:0] ext_o;
   logic                    sm_o;
   logic                    en_o;
   logic                    clr_o;

   logic        [ACC_W-1:0] acc;
   logic        [ACC_W-1:0] sum;
   logic                    add_ovf;

   assign stall    = out_valid && !out_ready;
   assign in_ready = rst_n && !stall;
   assign ext_in   = ext_mul(inp_a, inp_b, signed_mode);

   // ---- input -> intermediate stages ----
   generate
      if (STAGES == 1) begin : g_direct
         assign vld_o = in_valid && in_ready;
         assign ext_o = ext_in;
         assign sm_o  = signed_mode;
         assign en_o  = acc_en;
         assign clr_o = acc_clr;
      end else begin : g_pipe
         localparam int D = STAGES - 1;

         logic             vld_p [D];
         logic [ACC_W-1:0] ext_p [D];
         logic             sm_p  [D];
         logic             en_p  [D];
         logic             clr_p [D];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) vld_p[i] <= 1'b0;
            end else if (!stall) begin
               vld_p[0] <= in_valid;
               for (int i = 1; i < D; i++) vld_p[i] <= vld_p[i-1];
            end
         end

         // Payload is qualified by vld_p, so it carries no reset.
         always_ff @(posedge clk) begin
            if (!stall) begin
               ext_p[0] <= ext_in;
               sm_p[0]  <= signed_mode;
               en_p[0]  <= acc_en;
               clr_p[0] <= acc_clr;
               for (int i = 1; i < D; i++) begin
                  ext_p[i] <= ext_p[i-1];
                  sm_p[i]  <= sm_p[i-1];
                  en_p[i]  <= en_p[i-1];
                  clr_p[i] <= clr_p[i-1];
               end
            end
         end

         assign vld_o = vld_p[D-1];
         assign ext_o = ext_p[D-1];
         assign sm_o  = sm_p[D-1];
         assign en_o  = en_p[D-1];
         assign clr_o = clr_p[D-1];
      end
   endgenerate

   assign {add_ovf, sum} = acc_add(acc, ext_o, sm_o);

   // ---- output register / accumulator ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         prod      <= '0;
         acc       <= '0;
         acc_ovf   <= 1'b0;
      end else if (!stall) begin
         out_valid <= vld_o;
         if (vld_o) begin
            if (clr_o) begin
               acc     <= ext_o;
               prod    <= ext_o;
               acc_ovf <= 1'b0;
            end else if (en_o) begin
               acc  <= sum;
               prod <= sum;
               if (add_ovf) acc_ovf <= 1'b1;
            end else begin
               prod <= ext_o;
            end
         end
      end
   end

endmodule

// File: doc/pipe_mac.md
PIPE_MAC -- requirements
Module: pipe_mac

Interface
REQ-001 Parameter WIDTH, default 16, operand width (>= 2).
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages (1..8).
REQ-003 Parameter ACC_W, default 40, result/accumulator width (>= 2*WIDTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  beat accepted on an edge where in_valid && in_ready.
REQ-008 inp_a  input  WIDTH  operand A.
REQ-009 inp_b  input  WIDTH  operand B.
REQ-010 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled per beat.
REQ-011 acc_en  input  1  beat adds its product into accumulator; sampled per beat.
REQ-012 acc_clr  input  1  beat clears accumulator before adding; sampled per beat; overrides acc_en.
REQ-013 out_valid  output  1  result on prod valid.
REQ-014 out_ready  input  1  result consumed on an edge where out_valid && out_ready.
REQ-015 prod  output  ACC_W  result.
REQ-016 acc_ovf  output  1  sticky accumulator overflow flag.

Function
REQ-017 Each pipeline stage SHALL carry a valid bit plus the beat's signed_mode, acc_en, acc_clr alongside its data.
REQ-018 Stall = out_valid && !out_ready; in_ready SHALL equal !stall while rst_n high, and 0 while rst_n low.
REQ-019 When stall is low all stages SHALL advance one position per cycle; when high all stages SHALL hold, prod/out_valid unchanged.
REQ-020 Latency: beat accepted at edge k SHALL present out_valid=1 after edge k+STAGES-1, absent stall; throughput one beat per cycle.
REQ-021 Bubbles (in_valid low) SHALL propagate as invalid stages; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-022 Product SHALL be full 2*WIDTH bits, signed when signed_mode=1, then sign-extended (signed) or zero-extended (unsigned) to ACC_W.
REQ-023 Accumulator update SHALL occur only when a valid beat enters the output register.
REQ-024 acc_clr=1: acc <= ext_product, prod <= ext_product, acc_ovf <= 0.
REQ-025 acc_clr=0, acc_en=1: acc <= acc + ext_product modulo 2^ACC_W, prod <= new acc.
REQ-026 acc_clr=0, acc_en=0: prod <= ext_product, acc unchanged (plain multiply).
REQ-027 acc_ovf SHALL set when an accumulating add overflows ACC_W: unsigned carry-out for signed_mode=0, signed overflow for signed_mode=1; remains set until acc_clr beat or reset.
REQ-028 Invalid beats SHALL not modify acc or acc_ovf.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits, acc, prod (0), out_valid (0), acc_ovf (0), independent of clk.
REQ-030 Beats in flight at reset assertion SHALL be discarded; first beat after release SHALL see acc=0.
REQ-031 After rst_n rises, in_ready SHALL be 1 in the same cycle.

Verification
REQ-032 Defaults, unsigned, acc_en=0: a=3, b=5 accepted at edge k -> out_valid after edge k+1, prod=15.
REQ-033 a=16'hFFFF, b=2: signed_mode=1 -> prod=40'hFF_FFFF_FFFE; signed_mode=0 -> prod=40'h0_0001_FFFE.
REQ-034 Back-to-back beats (2,3,clr), (4,5,en), (1,1,en) -> prod 6, 26, 27 on consecutive cycles.
REQ-035 Pipe full, out_ready low 3 cycles -> in_ready low 3 cycles, prod stable, then outputs resume in order with no loss.
REQ-036 Unsigned accumulate of 16'hFFFF*16'hFFFF, first beat acc_clr -> acc_ovf rises on 257th beat, stays set, clears on next acc_clr beat.
REQ-037 rst_n pulsed low with 2 beats in flight -> out_valid 0 immediately, neither beat emerges, next (2,2,en) beat yields prod=4.
